// File: rtl/dsack_responder.sv
`timescale 1ns/1ps
// dsack_responder: region-timed DSACK/BERR generator. BUS_TIMEOUT_EN adds the unselected-cycle bus timeout.
// Latency: DSACK at edge 4+W after AS_n falls. No backpressure: an ack or error holds until AS_n rises.
module dsack_responder #(
  parameter int          ROM_WAIT = 3,
  parameter int          RAM_WAIT = 1,
  parameter int          IO_WAIT  = 6,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       AS_n,
  input  logic       CS_ROM_n,
  input  logic       CS_RAM_n,
  input  logic       CS_IO_n,
  output logic [1:0] DSACK_n,
  output logic       BERR_n
);

  function automatic logic [3:0] sat4(input int v);
    logic [3:0] r;
    if (v > 15)     r = 4'd15;
    else if (v < 0) r = 4'd0;
    else            r = v[3:0];
    return r;
  endfunction

  localparam logic [3:0] ROM_W = sat4(ROM_WAIT);
  localparam logic [3:0] RAM_W = sat4(RAM_WAIT);
  localparam logic [3:0] IO_W  = sat4(IO_WAIT);

  localparam logic [1:0] DSACK_8BIT  = 2'b10;
  localparam logic [1:0] DSACK_32BIT = 2'b00;
  localparam logic [1:0] DSACK_NONE  = 2'b11;

  typedef enum logic [1:0] {
    REG_ROM,
    REG_RAM,
    REG_IO
  } region_t;

`ifdef BUS_TIMEOUT_EN
  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACK,
    NOSEL,
    ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACK,
    NOSEL
  } state_t;
`endif

  logic       as_meta;
  logic       as_s;
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  region_t    region_q, region_d;
  logic [1:0] dsack_q, dsack_d;

  // AS_n is asynchronous; only the second flop's output may reach the FSM.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      as_meta <= 1'b1;
      as_s    <= 1'b1;
    end else begin
      as_meta <= AS_n;
      as_s    <= as_meta;
    end
  end

`ifdef BUS_TIMEOUT_EN
  logic [7:0] timer_q, timer_d;
  logic [7:0] timer_inc;
  logic       tmo_hit;
  logic       berr_q, berr_d;

  assign timer_inc = timer_q + 8'd1;
  // ERR is entered on the same edge the timer reaches TIMEOUT, so BERR lands TIMEOUT clocks after NOSEL entry.
  assign tmo_hit   = (TIMEOUT == 8'd0) || (timer_inc == TIMEOUT);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    region_d = region_q;
`ifdef BUS_TIMEOUT_EN
    timer_d  = timer_q;
`endif
    case (state_q)
      IDLE: begin
        if (!as_s) begin
          if (!CS_ROM_n) begin
            region_d = REG_ROM;
            cnt_d    = ROM_W;
            state_d  = WAIT;
          end else if (!CS_RAM_n) begin
            region_d = REG_RAM;
            cnt_d    = RAM_W;
            state_d  = WAIT;
          end else if (!CS_IO_n) begin
            region_d = REG_IO;
            cnt_d    = IO_W;
            state_d  = WAIT;
          end else begin
`ifdef BUS_TIMEOUT_EN
            timer_d  = 8'd0;
`endif
            state_d  = NOSEL;
          end
        end
      end
      WAIT: begin
        if (as_s)               state_d = IDLE;
        else if (cnt_q == 4'd0) state_d = ACK;
        else                    cnt_d   = cnt_q - 4'd1;
      end
      ACK: begin
        if (as_s) state_d = IDLE;
      end
      NOSEL: begin
        if (as_s) begin
          state_d = IDLE;
        end else begin
`ifdef BUS_TIMEOUT_EN
          timer_d = timer_inc;
          if (tmo_hit) state_d = ERR;
`endif
        end
      end
`ifdef BUS_TIMEOUT_EN
      ERR: begin
        if (as_s) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the transition edge itself.
  always_comb begin
    dsack_d = DSACK_NONE;
    if (state_d == ACK)
      dsack_d = (region_d == REG_RAM) ? DSACK_32BIT : DSACK_8BIT;
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      region_q <= REG_ROM;
      dsack_q  <= DSACK_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      region_q <= region_d;
      dsack_q  <= dsack_d;
    end
  end

  assign DSACK_n = dsack_q;

`ifdef BUS_TIMEOUT_EN
  assign berr_d = (state_d != ERR);

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      timer_q <= 8'd0;
      berr_q  <= 1'b1;
    end else begin
      timer_q <= timer_d;
      berr_q  <= berr_d;
    end
  end

  assign BERR_n = berr_q;
`else
  assign BERR_n = 1'b1;
`endif

endmodule
